rv_regfile_access_ctrl: RTL and testbench

Requester-side controller for the pipeline's 2-read/1-write synchronous register-file RAM (`bsg_mem_2r1w_sync`, `read_write_same_addr_p=0`). It turns decode-stage rs1/rs2 read requests into RAM read-port strobes and writeback-stage writes into RAM write strobes. It covers what the RAM does not provide: x0 hard-wiring, same-cycle write/read collision bypass, and holding of the one-cycle-late read data under downstream stall, so the RAM never sees a same-address read and write.

---
 rtl/rv_regfile_pkg.sv | 23 ++
 rtl/rv_regfile_access_ctrl_rd_slot.sv | 86 ++++++++
 rtl/rv_regfile_access_ctrl.sv | 101 ++++++++++
 tb/tb_rv_regfile_access_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_regfile_pkg.sv
// Shared types and constants for the register-file access controller.
package rv_regfile_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FRESH = 2'd1,
      HELD  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SRC_MEM  = 2'd0,
      SRC_BYP  = 2'd1,
      SRC_ZERO = 2'd2
   } src_e;

   localparam int unsigned RV_X0 = 0;

   // Index width that stays at least one bit for a single-entry file.
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rv_regfile_access_ctrl_rd_slot.sv
// One read port: source select, bypass capture, stall hold and writeback forwarding.
module rv_regfile_rd_slot
   import rv_regfile_pkg::*;
#(
   parameter int unsigned width_p      = 32,
   parameter int unsigned addr_width_p = 5
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  state_e                  state_i,
   input  logic                    acc_i,
   input  logic                    consume_i,
   input  logic [addr_width_p-1:0] addr_i,
   input  logic                    w_v_i,
   input  logic [addr_width_p-1:0] w_addr_i,
   input  logic [width_p-1:0]      w_data_i,
   input  logic [width_p-1:0]      mem_data_i,
   output logic                    mem_v_o,
   output logic [addr_width_p-1:0] mem_addr_o,
   output logic [width_p-1:0]      data_o
);

   src_e                    src_sel;
   src_e                    src_q;
   logic [addr_width_p-1:0] addr_q;
   logic [width_p-1:0]      byp_q;
   logic [width_p-1:0]      hold_q;
   logic [width_p-1:0]      fresh_val;
   logic                    fwd;

   // x0 wins over a collision; a colliding write is taken from the writeback bus.
   always_comb begin
      src_sel = SRC_MEM;
      if (addr_i == addr_width_p'(RV_X0)) begin
         src_sel = SRC_ZERO;
      end else if (w_v_i && (addr_i == w_addr_i)) begin
         src_sel = SRC_BYP;
      end
   end

   assign mem_v_o    = acc_i & (src_sel == SRC_MEM);
   assign mem_addr_o = addr_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         src_q  <= SRC_ZERO;
         addr_q <= '0;
         byp_q  <= '0;
         hold_q <= '0;
      end else begin
         if (acc_i) begin
            src_q  <= src_sel;
            addr_q <= addr_i;
            if (src_sel == SRC_BYP) begin
               byp_q <= w_data_i;
            end
         end
         if ((state_i != EMPTY) && !consume_i) begin
            hold_q <= data_o;
         end
      end
   end

   assign fwd = w_v_i & (addr_q != addr_width_p'(RV_X0)) & (w_addr_i == addr_q);

   always_comb begin
      fresh_val = '0;
      case (src_q)
         SRC_MEM:  fresh_val = mem_data_i;
         SRC_BYP:  fresh_val = byp_q;
         default:  fresh_val = '0;
      endcase
   end

   // A writeback landing while the operand is presented overrides the captured value.
   always_comb begin
      data_o = hold_q;
      if (state_i == FRESH) begin
         data_o = fresh_val;
      end
      if ((state_i != EMPTY) && fwd) begin
         data_o = w_data_i;
      end
   end

endmodule

// File: rtl/rv_regfile_access_ctrl.sv
// Requester-side controller for a 2r1w synchronous register-file RAM.
module rv_regfile_access_ctrl
   import rv_regfile_pkg::*;
#(
   parameter int unsigned width_p       = 32,
   parameter int unsigned els_p         = 32,
   parameter int unsigned addr_width_lp = safe_clog2(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     v_i,
   output logic                     ready_o,
   input  logic [addr_width_lp-1:0] rs1_addr_i,
   input  logic [addr_width_lp-1:0] rs2_addr_i,
   input  logic                     wb_v_i,
   input  logic [addr_width_lp-1:0] wb_addr_i,
   input  logic [width_p-1:0]       wb_data_i,
   output logic                     v_o,
   input  logic                     ready_i,
   output logic [width_p-1:0]       rs1_data_o,
   output logic [width_p-1:0]       rs2_data_o,
   output logic                     mem_w_v_o,
   output logic [addr_width_lp-1:0] mem_w_addr_o,
   output logic [width_p-1:0]       mem_w_data_o,
   output logic                     mem_r0_v_o,
   output logic [addr_width_lp-1:0] mem_r0_addr_o,
   input  logic [width_p-1:0]       mem_r0_data_i,
   output logic                     mem_r1_v_o,
   output logic [addr_width_lp-1:0] mem_r1_addr_o,
   input  logic [width_p-1:0]       mem_r1_data_i
);

   state_e state_q;
   logic   consume;
   logic   acc;

   assign v_o     = (state_q != EMPTY);
   assign consume = v_o & ready_i;
   assign ready_o = ~reset_i & ((state_q == EMPTY) | consume);
   assign acc     = v_i & ready_o;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (acc) state_q <= FRESH;
            FRESH,
            HELD: begin
               if (consume) state_q <= acc ? FRESH : EMPTY;
               else         state_q <= HELD;
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   // Writes to x0 never reach the RAM.
   assign mem_w_v_o    = wb_v_i & (wb_addr_i != addr_width_lp'(RV_X0));
   assign mem_w_addr_o = wb_addr_i;
   assign mem_w_data_o = wb_data_i;

   rv_regfile_rd_slot #(
      .width_p      (width_p),
      .addr_width_p (addr_width_lp)
   ) u_slot_rs1 (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .state_i    (state_q),
      .acc_i      (acc),
      .consume_i  (consume),
      .addr_i     (rs1_addr_i),
      .w_v_i      (mem_w_v_o),
      .w_addr_i   (wb_addr_i),
      .w_data_i   (wb_data_i),
      .mem_data_i (mem_r0_data_i),
      .mem_v_o    (mem_r0_v_o),
      .mem_addr_o (mem_r0_addr_o),
      .data_o     (rs1_data_o)
   );

   rv_regfile_rd_slot #(
      .width_p      (width_p),
      .addr_width_p (addr_width_lp)
   ) u_slot_rs2 (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .state_i    (state_q),
      .acc_i      (acc),
      .consume_i  (consume),
      .addr_i     (rs2_addr_i),
      .w_v_i      (mem_w_v_o),
      .w_addr_i   (wb_addr_i),
      .w_data_i   (wb_data_i),
      .mem_data_i (mem_r1_data_i),
      .mem_v_o    (mem_r1_v_o),
      .mem_addr_o (mem_r1_addr_o),
      .data_o     (rs2_data_o)
   );

endmodule

// File: tb/tb_rv_regfile_access_ctrl.sv
// Directed scoreboard bench for rv_regfile_access_ctrl with a behavioural 2r1w sync RAM.
module tb_rv_regfile_access_ctrl;

   localparam int unsigned W  = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          v_i;
   logic          ready_o;
   logic [AW-1:0] rs1_addr_i;
   logic [AW-1:0] rs2_addr_i;
   logic          wb_v_i;
   logic [AW-1:0] wb_addr_i;
   logic [W-1:0]  wb_data_i;
   logic          v_o;
   logic          ready_i;
   logic [W-1:0]  rs1_data_o;
   logic [W-1:0]  rs2_data_o;
   logic          mem_w_v_o;
   logic [AW-1:0] mem_w_addr_o;
   logic [W-1:0]  mem_w_data_o;
   logic          mem_r0_v_o;
   logic [AW-1:0] mem_r0_addr_o;
   logic [W-1:0]  mem_r0_data_i;
   logic          mem_r1_v_o;
   logic [AW-1:0] mem_r1_addr_o;
   logic [W-1:0]  mem_r1_data_i;

   rv_regfile_access_ctrl #(.width_p(W), .els_p(32)) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .v_i           (v_i),
      .ready_o       (ready_o),
      .rs1_addr_i    (rs1_addr_i),
      .rs2_addr_i    (rs2_addr_i),
      .wb_v_i        (wb_v_i),
      .wb_addr_i     (wb_addr_i),
      .wb_data_i     (wb_data_i),
      .v_o           (v_o),
      .ready_i       (ready_i),
      .rs1_data_o    (rs1_data_o),
      .rs2_data_o    (rs2_data_o),
      .mem_w_v_o     (mem_w_v_o),
      .mem_w_addr_o  (mem_w_addr_o),
      .mem_w_data_o  (mem_w_data_o),
      .mem_r0_v_o    (mem_r0_v_o),
      .mem_r0_addr_o (mem_r0_addr_o),
      .mem_r0_data_i (mem_r0_data_i),
      .mem_r1_v_o    (mem_r1_v_o),
      .mem_r1_addr_o (mem_r1_addr_o),
      .mem_r1_data_i (mem_r1_data_i)
   );

   always #5 clk = ~clk;

   logic [W-1:0] ram [32];
   logic [W-1:0] ref_regs [32];

   // Synchronous-read RAM; read data holds until the next read on that port.
   always @(posedge clk) begin
      if (mem_w_v_o)  ram[mem_w_addr_o] <= mem_w_data_o;
      if (mem_r0_v_o) mem_r0_data_i <= ram[mem_r0_addr_o];
      if (mem_r1_v_o) mem_r1_data_i <= ram[mem_r1_addr_o];
   end

   typedef struct packed {
      logic [W-1:0] d1;
      logic [W-1:0] d2;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // RAM same-address guard and operand scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      chk("ram_r0_same_addr", W'(mem_w_v_o & mem_r0_v_o & (mem_w_addr_o == mem_r0_addr_o)), '0);
      chk("ram_r1_same_addr", W'(mem_w_v_o & mem_r1_v_o & (mem_w_addr_o == mem_r1_addr_o)), '0);
      if (v_o && ready_i) begin
         if (exp_q.size() == 0) begin
            chk("queue_underflow", W'(exp_q.size()), W'(1));
         end else begin
            e = exp_q.pop_front();
            chk("rs1_data", rs1_data_o, e.d1);
            chk("rs2_data", rs2_data_o, e.d2);
         end
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                        input logic push);
      v_i        = v;
      rs1_addr_i = a1;
      rs2_addr_i = a2;
      wb_v_i     = wv;
      wb_addr_i  = wa;
      wb_data_i  = wd;
      if (wv && (wa != '0)) ref_regs[wa] = wd;
      if (push) exp_q.push_back({ref_regs[a1], ref_regs[a2]});
   endtask

   initial begin
      logic [AW-1:0] a1;
      for (int k = 0; k < 32; k++) begin
         ram[k]      = 32'hA000_0000 | W'(k);
         ref_regs[k] = 32'hA000_0000 | W'(k);
      end
      ram[0]      = 32'hBAD0_0000;
      ref_regs[0] = '0;
      ram[5] = 32'h55; ref_regs[5] = 32'h55;
      ram[6] = 32'h66; ref_regs[6] = 32'h66;
      mem_r0_data_i = '0;
      mem_r1_data_i = '0;

      reset_i = 1'b1;
      ready_i = 1'b1;
      drive(1'b1, 5'd5, 5'd6, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk("rst_v_o",     W'(v_o), '0);
      chk("rst_ready_o", W'(ready_o), '0);
      chk("rst_rs1",     rs1_data_o, '0);
      chk("rst_rs2",     rs2_data_o, '0);
      chk("rst_r0_v",    W'(mem_r0_v_o), '0);
      chk("rst_r1_v",    W'(mem_r1_v_o), '0);

      // First request straight after reset release.
      next_cyc();
      reset_i = 1'b0;
      drive(1'b1, 5'd5, 5'd6, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      chk("rel_ready_o", W'(ready_o), W'(1));
      chk("rd_r0_v",     W'(mem_r0_v_o), W'(1));
      chk("rd_r1_v",     W'(mem_r1_v_o), W'(1));
      chk("rd_r0_addr",  W'(mem_r0_addr_o), W'(5));
      chk("rd_r1_addr",  W'(mem_r1_addr_o), W'(6));

      // x0 reads while writing x0.
      next_cyc();
      drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD, 1'b1);
      @(negedge clk);
      chk("x0_r0_v",   W'(mem_r0_v_o), '0);
      chk("x0_r1_v",   W'(mem_r1_v_o), '0);
      chk("x0_w_v",    W'(mem_w_v_o), '0);
      chk("x0_ready",  W'(ready_o), W'(1));

      // Same-cycle write/read collision on both ports.
      next_cyc();
      drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h1234, 1'b1);
      @(negedge clk);
      chk("col_r0_v", W'(mem_r0_v_o), '0);
      chk("col_r1_v", W'(mem_r1_v_o), '0);
      chk("col_w_v",  W'(mem_w_v_o), W'(1));

      // Stall: x5 requested, overwritten in the second stall cycle.
      next_cyc();
      drive(1'b1, 5'd5, 5'd5, 1'b0, '0, '0, 1'b0);
      exp_q.push_back({32'h99, 32'h99});
      @(negedge clk);
      chk("stl_req_r0_v", W'(mem_r0_v_o), W'(1));
      next_cyc();
      ready_i = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk("stl1_ready_o", W'(ready_o), '0);
      chk("stl1_v_o",     W'(v_o), W'(1));
      chk("stl1_rs1",     rs1_data_o, 32'h55);
      chk("stl1_rs2",     rs2_data_o, 32'h55);
      next_cyc();
      drive(1'b1, 5'd9, 5'd9, 1'b1, 5'd5, 32'h99, 1'b0);
      @(negedge clk);
      chk("stl2_ready_o", W'(ready_o), '0);
      chk("stl2_r0_v",    W'(mem_r0_v_o), '0);
      chk("stl2_rs1",     rs1_data_o, 32'h99);
      chk("stl2_rs2",     rs2_data_o, 32'h99);
      next_cyc();
      drive(1'b1, 5'd9, 5'd9, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk("stl3_ready_o", W'(ready_o), '0);
      chk("stl3_rs1",     rs1_data_o, 32'h99);
      chk("stl3_rs2",     rs2_data_o, 32'h99);
      next_cyc();
      ready_i = 1'b1;
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk("stl_rel_ready_o", W'(ready_o), W'(1));

      // Back-to-back requests; even slots collide rs1 with the writeback.
      for (int i = 0; i < 8; i++) begin
         next_cyc();
         a1 = (i % 2 == 0) ? AW'(16 + i) : AW'(8 + i);
         drive(1'b1, a1, AW'(31 - i), 1'b1, AW'(16 + i), 32'hC000_0000 | W'(i), 1'b1);
         @(negedge clk);
         if (i > 0) chk("b2b_v_o", W'(v_o), W'(1));
         chk("b2b_r0_v", W'(mem_r0_v_o), W'(i % 2));
         chk("b2b_r1_v", W'(mem_r1_v_o), W'(1));
      end
      next_cyc();
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk("b2b_tail_v_o", W'(v_o), W'(1));
      next_cyc();
      @(negedge clk);
      chk("drain_v_o", W'(v_o), '0);

      // Asynchronous reset while an operand is held.
      next_cyc();
      drive(1'b1, 5'd6, 5'd5, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk("hr_ready_o", W'(ready_o), W'(1));
      next_cyc();
      ready_i = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      next_cyc();
      @(negedge clk);
      chk("hr_held_v_o", W'(v_o), W'(1));
      #2;
      reset_i = 1'b1;
      #1;
      chk("hr_async_v_o", W'(v_o), '0);
      chk("hr_async_rs1", rs1_data_o, '0);
      chk("hr_async_ready_o", W'(ready_o), '0);
      next_cyc();
      reset_i = 1'b0;
      ready_i = 1'b1;
      drive(1'b1, 5'd6, 5'd9, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      chk("hr_rel_ready_o", W'(ready_o), W'(1));
      chk("hr_rel_r0_v",    W'(mem_r0_v_o), W'(1));
      next_cyc();
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      next_cyc();
      @(negedge clk);
      chk("scoreboard_drained", W'(exp_q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
